// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: runs the CPU's VRAM updates. It draws CHIP-8/SCHIP
// DXYN sprites as an XOR read-modify-write with collision detect, and it
// clears the whole screen. The CPU issues one command at a time and then
// waits on busy/done.
module sprite_draw_engine #(
   parameter int SCREEN_W = 128,  // pixel columns, must match 7-bit hpos
   parameter int SCREEN_H = 64,   // pixel rows, must match 6-bit vpos
   parameter bit CLIP     = 1'b1  // 1: drop pixels past right/bottom edge, 0: wrap
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [6:0]  x,
   input  logic [5:0]  y,
   input  logic [3:0]  n,
   input  logic [11:0] i_addr,
   input  logic [1:0]  plane,
   output logic        busy,
   output logic        done,
   output logic        collision,
   output logic [11:0] ram_addr,
   input  logic [7:0]  ram_dout,
   output logic [6:0]  vram_hpos,
   output logic [5:0]  vram_vpos,
   output logic [1:0]  vram_pixeli,
   input  logic [1:0]  vram_pixelo,
   output logic        vram_we
);

   localparam logic [7:0] SCREEN_W8 = 8'(SCREEN_W);
   localparam logic [6:0] SCREEN_H7 = 7'(SCREEN_H);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_FWAIT, S_SCAN, S_RD, S_WR, S_CLR, S_DONE
   } state_t;

   state_t      state, state_nx, adv_state;

   // Operands latched at command start
   logic [6:0]  x_l;
   logic [5:0]  y_l;
   logic [11:0] base_l;
   logic [1:0]  plane_l;
   logic        wide;       // 16x16 SCHIP sprite, two bytes per row
   logic [3:0]  last_row;

   // Walk position inside the sprite
   logic [3:0]  row;
   logic        byte_sel;   // which byte of a wide row
   logic [2:0]  bit_idx;    // column inside the current byte
   logic [7:0]  shreg;      // current sprite byte, MSB is the pixel under scan
   logic [1:0]  old;        // pixel value read back before the XOR write
   logic [12:0] clr_cnt;    // {vpos, hpos} during a clear

   logic [7:0]  px_full;
   logic [6:0]  py_full;
   logic        clipped, hit, last_bit, advance;

   // Pixel coordinates under scan, clip test, and where the walk goes next
   always_comb begin
      px_full  = {1'b0, x_l} + {4'd0, byte_sel, bit_idx};
      py_full  = {1'b0, y_l} + {3'd0, row};
      clipped  = CLIP && ((px_full >= SCREEN_W8) || (py_full >= SCREEN_H7));
      hit      = shreg[7] && !clipped;
      last_bit = (bit_idx == 3'd7);
      advance  = ((state == S_SCAN) && !hit) || (state == S_WR);
      if (!last_bit)
         adv_state = S_SCAN;
      else if (wide && !byte_sel)
         adv_state = S_FETCH;
      else if (row == last_row)
         adv_state = S_DONE;
      else
         adv_state = S_FETCH;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge values, regardless of statement order.
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      // NOTE: the default first means every path assigns state_nx, so no
      // latch can be inferred when a case arm leaves it untouched.
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = op ? S_CLR : S_FETCH;
         S_FETCH: state_nx = S_FWAIT;
         S_FWAIT: state_nx = S_SCAN;
         S_SCAN:  state_nx = hit ? S_RD : adv_state;
         S_RD:    state_nx = S_WR;
         S_WR:    state_nx = adv_state;
         S_CLR:   if (clr_cnt == 13'h1fff) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // RAM and VRAM port drive; address stays put from SCAN through WR
   always_comb begin
      ram_addr    = 12'd0;
      vram_hpos   = 7'd0;
      vram_vpos   = 6'd0;
      vram_pixeli = 2'b00;
      vram_we     = 1'b0;
      case (state)
         S_FETCH: ram_addr = wide ? base_l + {7'd0, row, byte_sel}
                                  : base_l + {8'd0, row};
         S_SCAN, S_RD: begin
            vram_hpos = px_full[6:0];
            vram_vpos = py_full[5:0];
         end
         S_WR: begin
            vram_hpos   = px_full[6:0];
            vram_vpos   = py_full[5:0];
            vram_pixeli = old ^ plane_l;
            vram_we     = 1'b1;
         end
         S_CLR: begin
            vram_hpos = clr_cnt[6:0];
            vram_vpos = clr_cnt[12:7];
            vram_we   = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand latch, sprite walk, collision and handshake registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_l       <= '0;
         y_l       <= '0;
         base_l    <= '0;
         plane_l   <= '0;
         wide      <= 1'b0;
         last_row  <= '0;
         row       <= '0;
         byte_sel  <= 1'b0;
         bit_idx   <= '0;
         shreg     <= '0;
         old       <= '0;
         clr_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         collision <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               x_l      <= x;
               y_l      <= y;
               base_l   <= i_addr;
               plane_l  <= plane;
               wide     <= (n == 4'd0);
               last_row <= (n == 4'd0) ? 4'd15 : n - 4'd1;
               row      <= '0;
               byte_sel <= 1'b0;
               bit_idx  <= '0;
               clr_cnt  <= '0;
               busy     <= 1'b1;
               // Only a draw resets VF; a clear leaves it as it was
               if (!op) collision <= 1'b0;
            end
            S_FWAIT: shreg <= ram_dout;
            S_RD:    old   <= vram_pixelo;
            S_WR:    if ((old & plane_l) != 2'b00) collision <= 1'b1;
            S_CLR:   clr_cnt <= clr_cnt + 13'd1;
            S_DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: ;
         endcase
         if (advance) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_idx <= bit_idx + 3'd1;
            if (last_bit) begin
               if (wide && !byte_sel) begin
                  byte_sel <= 1'b1;
               end else begin
                  byte_sel <= 1'b0;
                  row      <= row + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb_sprite_draw_engine: drives a clipping and a wrapping engine with the
// same commands. A sprite-level reference frame predicts each result, and a
// done-triggered monitor scores it against the VRAM model.
module tb_sprite_draw_engine;

   logic clk = 1'b0;
   logic reset;
   logic start, op;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [3:0]  n;
   logic [11:0] i_addr;
   logic [1:0]  plane;

   // Index 0: CLIP=1 engine, index 1: CLIP=0 engine
   logic [1:0]        busy, done, collision, vram_we;
   logic [1:0][11:0]  ram_addr;
   logic [1:0][7:0]   ram_dout;
   logic [1:0][6:0]   hpos;
   logic [1:0][5:0]   vpos;
   logic [1:0][1:0]   pixeli, pixelo;

   logic [7:0] ram  [4096];
   logic [1:0] vram [2][64][128];
   logic [1:0] refm [2][64][128];
   int         wr_cnt [2] = '{0, 0};
   int         wr_base[2] = '{0, 0};
   int         cyc = 0;
   int         start_cyc = 0;
   bit         fill_req = 1'b0;
   bit         last_coll[2] = '{1'b0, 1'b0};

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      bit coll;
      int cycles;
      int writes;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   sprite_draw_engine #(.CLIP(1'b1)) dut_clip (
      .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y), .n(n),
      .i_addr(i_addr), .plane(plane), .busy(busy[0]), .done(done[0]),
      .collision(collision[0]), .ram_addr(ram_addr[0]), .ram_dout(ram_dout[0]),
      .vram_hpos(hpos[0]), .vram_vpos(vpos[0]), .vram_pixeli(pixeli[0]),
      .vram_pixelo(pixelo[0]), .vram_we(vram_we[0])
   );

   sprite_draw_engine #(.CLIP(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y), .n(n),
      .i_addr(i_addr), .plane(plane), .busy(busy[1]), .done(done[1]),
      .collision(collision[1]), .ram_addr(ram_addr[1]), .ram_dout(ram_dout[1]),
      .vram_hpos(hpos[1]), .vram_vpos(vpos[1]), .vram_pixeli(pixeli[1]),
      .vram_pixelo(pixelo[1]), .vram_we(vram_we[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Synchronous RAM and VRAM models, one of each per engine
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (fill_req) begin
            for (int r = 0; r < 64; r++)
               for (int c = 0; c < 128; c++)
                  vram[k][r][c] <= 2'b11;
         end else if (vram_we[k]) begin
            vram[k][vpos[k]][hpos[k]] <= pixeli[k];
            wr_cnt[k] <= wr_cnt[k] + 1;
         end
         pixelo[k]   <= vram[k][vpos[k]][hpos[k]];
         ram_dout[k] <= ram[ram_addr[k]];
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain per-pixel sprite rules on a bench-held frame
   task automatic model_draw(input int k, input logic [6:0] xx, input logic [5:0] yy,
                             input logic [3:0] nn, input logic [11:0] ia,
                             input logic [1:0] pl, output exp_t e);
      int rows, width, hits, px, py;
      logic [11:0] a;
      logic [7:0]  b;
      logic [1:0]  o;
      bit          coll;
      rows  = (nn == 4'd0) ? 16 : int'(nn);
      width = (nn == 4'd0) ? 16 : 8;
      hits  = 0;
      coll  = 1'b0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < width; c++) begin
            a = (nn == 4'd0) ? ia + 12'(2 * r + c / 8) : ia + 12'(r);
            b = ram[a];
            if (b[7 - (c % 8)]) begin
               px = int'(xx) + c;
               py = int'(yy) + r;
               if (!(k == 0 && (px >= 128 || py >= 64))) begin
                  px = px % 128;
                  py = py % 64;
                  o  = refm[k][py][px];
                  if ((o & pl) != 2'b00) coll = 1'b1;
                  refm[k][py][px] = o ^ pl;
                  hits++;
               end
            end
         end
      end
      e.coll      = coll;
      e.writes    = hits;
      e.cycles    = (rows * width / 8) * 10 + 2 * hits + 2;
      last_coll[k] = coll;
   endtask

   task automatic model_clear(input int k, output exp_t e);
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 128; c++)
            refm[k][r][c] = 2'b00;
      e.coll   = last_coll[k];
      e.writes = 8192;
      e.cycles = 8194;
   endtask

   task automatic score(input int k);
      exp_t e;
      int   diffs;
      if ((k == 0 ? q0.size() : q1.size()) == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_done[%0d]: got done=1, expected no command in flight", k);
         return;
      end
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      diffs = 0;
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 128; c++)
            if (vram[k][r][c] != refm[k][r][c]) diffs++;
      check($sformatf("cycles[%0d]", k), cyc - start_cyc, e.cycles);
      check($sformatf("writes[%0d]", k), wr_cnt[k] - wr_base[k], e.writes);
      check($sformatf("collision[%0d]", k), collision[k], e.coll);
      check($sformatf("frame_diffs[%0d]", k), diffs, 0);
      check($sformatf("busy_at_done[%0d]", k), busy[k], 0);
   endtask

   // Monitors: score whenever an engine signals completion
   always @(posedge clk) begin
      #1;
      if (done[0]) score(0);
   end

   always @(posedge clk) begin
      #1;
      if (done[1]) score(1);
   end

   task automatic run_cmd(input bit o, input logic [6:0] xx, input logic [5:0] yy,
                          input logic [3:0] nn, input logic [11:0] ia,
                          input logic [1:0] pl, input bit poke);
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (o) model_clear(k, e);
         else   model_draw(k, xx, yy, nn, ia, pl, e);
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
         wr_base[k] = wr_cnt[k];
      end
      @(negedge clk);
      op = o; x = xx; y = yy; n = nn; i_addr = ia; plane = pl;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 2'b11);
      if (poke) begin
         // A second command while busy must not disturb the one running
         repeat (3) @(negedge clk);
         op = ~o; x = ~xx; y = ~yy; n = nn + 4'd1; i_addr = ia + 12'h123; plane = ~pl;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int t = 0; t < 20000 && (q0.size() + q1.size()) > 0; t++) @(posedge clk);
      @(negedge clk);
      if ((q0.size() + q1.size()) != 0) begin
         check("done_timeout", q0.size() + q1.size(), 0);
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0;
      x = '0; y = '0; n = '0; i_addr = '0; plane = '0;
      for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
      fill_req = 1'b1;
      repeat (2) @(negedge clk);
      fill_req = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
               refm[k][r][c] = 2'b11;

      // Reset values
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_collision", collision, 0);
      check("rst_vram_we", vram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_hpos", hpos, 0);
      check("rst_vpos", vpos, 0);
      check("rst_pixeli", pixeli, 0);
      @(negedge clk);
      reset = 1'b0;

      // Clear aborted by reset partway through
      @(negedge clk);
      op = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_vram_we", vram_we, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("abort_cleared_00[%0d]", k), vram[k][0][0], 2'b00);
         check($sformatf("abort_cleared_50[%0d]", k), vram[k][0][50], 2'b00);
         check($sformatf("abort_kept_end[%0d]", k), vram[k][63][127], 2'b11);
      end

      // Full clear right after the abort
      run_cmd(1'b1, 7'd0, 6'd0, 4'd0, 12'd0, 2'b00, 1'b0);

      // Single-row draw, then the same draw to erase it with collision
      ram[12'h200] = 8'hFF;
      run_cmd(1'b0, 7'd0, 6'd0, 4'd1, 12'h200, 2'b01, 1'b0);
      run_cmd(1'b0, 7'd0, 6'd0, 4'd1, 12'h200, 2'b01, 1'b0);

      // Clear must leave VF at 1
      run_cmd(1'b1, 7'd0, 6'd0, 4'd0, 12'd0, 2'b00, 1'b0);

      // Corner sprite: clipped on one engine, wrapped on the other
      for (int a = 0; a < 4; a++) ram[12'h300 + a] = 8'hFF;
      run_cmd(1'b0, 7'd124, 6'd62, 4'd4, 12'h300, 2'b01, 1'b0);

      // 16x16 SCHIP sprite with a start pulse while busy
      for (int a = 0; a < 32; a++) ram[12'h400 + a] = 8'hFF;
      run_cmd(1'b0, 7'd10, 6'd5, 4'd0, 12'h400, 2'b10, 1'b1);

      // Random draws, including plane 00 and address wrap
      for (int i = 0; i < 12; i++)
         run_cmd(1'b0, 7'($urandom), 6'($urandom), 4'($urandom_range(0, 15)),
                 12'($urandom), 2'($urandom), 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Sequences all CPU-initiated VRAM updates: CHIP-8/SCHIP DXYN sprite draw, as an XOR read-modify-write with collision detect, and full-screen clear.
- Sits between cpu and vram. cpu issues one command and waits on busy/done.
- Owns a RAM read port for sprite bytes and drives the VRAM read/write port.

Parameters:
- SCREEN_W, 128, pixel columns. Must match the 7-bit hpos.
- SCREEN_H, 64, pixel rows. Must match the 6-bit vpos.
- CLIP, 1, edge handling. 1 = pixels past the right/bottom edge are dropped. 0 = they wrap modulo screen size.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; ignored while busy
- op  in  1  0 = draw sprite, 1 = clear screen
- x  in  7  sprite origin column
- y  in  6  sprite origin row
- n  in  4  sprite rows; 0 = 16x16 SCHIP sprite
- i_addr  in  12  sprite base address in RAM
- plane  in  2  plane mask XORed into each set sprite pixel
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- collision  out  1  VF result of the last draw
- ram_addr  out  12  sprite byte address
- ram_dout  in  8  RAM data, valid 1 cycle after ram_addr
- vram_hpos  out  7  pixel column
- vram_vpos  out  6  pixel row
- vram_pixeli  out  2  write data
- vram_pixelo  in  2  read data, valid 1 cycle after address
- vram_we  out  1  write enable for the addressed pixel

Behaviour:
- Reset values: busy=0, done=0, collision=0, vram_we=0, all address/data outputs 0, state IDLE.
- Reset mid-command aborts at once. VRAM keeps whatever was already written.
- Start latch: in IDLE, start=1 latches x, y, n, i_addr, plane and op, sets busy=1 next cycle.
  - Draw start clears collision.
  - Clear start leaves collision unchanged.
- Draw geometry:
  - n=0: 16 rows, 2 bytes per row (MSB byte first); bytes at i_addr+2*row and i_addr+2*row+1.
  - n>0: n rows, 1 byte per row at i_addr+row.
  - Bit 7 of each byte is the leftmost pixel.
- Origin wraps always: x mod 128, y mod 64.
- Per-pixel coordinates are x+col and y+row.
  - Clipped when they cross the edge and CLIP=1; otherwise wrapped (7-bit/6-bit truncation).
- Draw states:
  - FETCH: drive ram_addr (1 cycle).
  - FWAIT: latch ram_dout into a shift register (1 cycle).
  - SCAN, 1 cycle per bit: if bit=0 or clipped, advance. Else drive vram address and go to RD.
  - RD: capture vram_pixelo into old (1 cycle).
  - WR: vram_we=1, pixeli = old ^ plane. Set collision if (old & plane) != 0. Advance (1 cycle).
  - After the last bit of a byte: next byte, then next row, else DONE.
- Cycle counts:
  - Each byte costs 2 + 8 + 2*(set, unclipped bits) cycles.
  - plane=00 still scans but writes pixeli = old, never sets collision.
- Clear: CLR walks vpos 0..63 outer, hpos 0..127 inner. Each cycle writes pixeli=00 with vram_we=1 (8192 cycles), then DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
  - collision holds until the next draw start.
  - start is accepted again the cycle after DONE.
- vram_we is high only in WR and CLR. No two writes target the same pixel within one command.
- Read address is stable through RD.

Test Plan:
- Reset asserted mid-clear -> busy/done/vram_we=0 next edge. Remaining pixels are not cleared. Next start is accepted.
- Blank VRAM; draw x=0, y=0, n=1, plane=01, byte 0xFF:
  - Pixels (0..7,0) become 01, collision=0.
  - done rises 28 cycles after start.
- Same draw repeated -> pixels return to 00, collision=1.
- Draw x=124, y=62, n=4, byte 0xFF, CLIP=1 -> only columns 124..127 of rows 62..63 are written (8 writes).
- Same draw with CLIP=0 -> columns 0..3 and rows 0..1 are also written (32 writes total).
- n=0, 16x16 all-ones sprite at (10,5) -> 32 RAM reads at i_addr..i_addr+31, 256 pixels toggled.
- Clear op -> 8192 writes of 00, done pulse, collision unchanged.
- start pulsed while busy -> ignored; no change to latched operands.
